// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared 640x480@60 timing constants, framebuffer geometry,
//                sync polarity and the alignment-pipeline word layout used
//                by the VGA scanout read path.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_pkg;

    // 640x480@60 horizontal timing, in pixel ticks
    localparam int C_H_VISIBLE = 640;
    localparam int C_H_FRONT   = 16;
    localparam int C_H_SYNC    = 96;
    localparam int C_H_BACK    = 48;
    localparam int C_H_TOTAL   = C_H_VISIBLE + C_H_FRONT + C_H_SYNC + C_H_BACK;

    // 640x480@60 vertical timing, in lines
    localparam int C_V_VISIBLE = 480;
    localparam int C_V_FRONT   = 10;
    localparam int C_V_SYNC    = 2;
    localparam int C_V_BACK    = 33;
    localparam int C_V_TOTAL   = C_V_VISIBLE + C_V_FRONT + C_V_SYNC + C_V_BACK;

    // Framebuffer geometry and pixel format
    localparam int C_FB_W      = 160;
    localparam int C_FB_H      = 120;
    localparam int C_COLOUR_W  = 3;

    // Counter width: wide enough for both 800 and 525
    localparam int C_CNT_W     = 10;

    // Both syncs are active-low for this mode
    localparam logic C_SYNC_ACTIVE = 1'b0;

    // One stage of the sync/blank alignment pipeline
    typedef struct packed {
        logic visible;
        logic hs;
        logic vs;
    } align_t;

    // Pipeline contents after reset: blanked, sync deasserted
    localparam align_t C_ALIGN_IDLE = '{visible: 1'b0,
                                        hs:      ~C_SYNC_ACTIVE,
                                        vs:      ~C_SYNC_ACTIVE};

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Horizontal/vertical position counters for VGA scanout.
//                Produces the undelayed visible flag, raw syncs and a
//                one-clk frame_start pulse. All state advances on i_pix_en.
//  Ports       : clk, resetn       - clock, synchronous active-low reset
//                i_pix_en          - pixel-rate strobe
//                o_h_cnt, o_v_cnt  - current position
//                o_visible         - position lies in the active area
//                o_hs_raw/o_vs_raw - undelayed syncs (active-low)
//                o_frame_start     - pulse on the clk after the (0,0) tick
//  Revision    : 1.0  initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = C_H_VISIBLE,
    parameter int H_FRONT   = C_H_FRONT,
    parameter int H_SYNC    = C_H_SYNC,
    parameter int H_BACK    = C_H_BACK,
    parameter int V_VISIBLE = C_V_VISIBLE,
    parameter int V_FRONT   = C_V_FRONT,
    parameter int V_SYNC    = C_V_SYNC,
    parameter int V_BACK    = C_V_BACK,
    parameter int CNT_W     = C_CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_pix_en,
    output logic [CNT_W-1:0] o_h_cnt,
    output logic [CNT_W-1:0] o_v_cnt,
    output logic             o_visible,
    output logic             o_hs_raw,
    output logic             o_vs_raw,
    output logic             o_frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] C_H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] C_V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] C_H_VIS      = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] C_V_VIS      = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] C_HS_START   = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] C_HS_END     = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] C_VS_START   = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] C_VS_END     = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             r_frame_start;
    logic             w_at_origin;

    assign w_at_origin = (r_h_cnt == '0) && (r_v_cnt == '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_frame_start <= 1'b0;
        end else begin
            // The pulse is re-evaluated every clk so it is exactly one clk
            // wide even when i_pix_en is held high.
            r_frame_start <= i_pix_en && w_at_origin;
            if (i_pix_en) begin
                if (r_h_cnt == C_H_LAST) begin
                    r_h_cnt <= '0;
                    if (r_v_cnt == C_V_LAST) begin
                        r_v_cnt <= '0;
                    end else begin
                        r_v_cnt <= r_v_cnt + 1'b1;
                    end
                end else begin
                    r_h_cnt <= r_h_cnt + 1'b1;
                end
            end
        end
    end

    assign o_h_cnt       = r_h_cnt;
    assign o_v_cnt       = r_v_cnt;
    assign o_visible     = (r_h_cnt < C_H_VIS) && (r_v_cnt < C_V_VIS);
    assign o_hs_raw      = ((r_h_cnt >= C_HS_START) && (r_h_cnt < C_HS_END))
                           ? C_SYNC_ACTIVE : ~C_SYNC_ACTIVE;
    assign o_vs_raw      = ((r_v_cnt >= C_VS_START) && (r_v_cnt < C_VS_END))
                           ? C_SYNC_ACTIVE : ~C_SYNC_ACTIVE;
    assign o_frame_start = r_frame_start;

endmodule : vga_timing_gen
`default_nettype wire

// File: rtl/vga_scanout_reader.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scanout_reader
//  Description : Read side of the 160x120 framebuffer. Generates VGA timing,
//                issues one framebuffer read per displayed pixel (4x upscale)
//                and realigns the returned colour with delayed sync/blank so
//                every VGA output changes on the same pix_en tick.
//  Ports       : clk, resetn   - clock, synchronous active-low reset
//                pix_en        - pixel-rate strobe
//                rd_x/rd_y     - framebuffer read address (0 when blanked)
//                rd_en         - read request, high on visible pixels
//                rd_colour     - read data, MEM_LATENCY ticks after address
//                vga_colour    - output colour, 0 when blanked
//                vga_hs/vga_vs - active-low syncs
//                vga_blank_n   - low outside the visible area
//                frame_start   - one-clk pulse after the (0,0) tick
//  Revision    : 1.0  initial release
// ============================================================================
module vga_scanout_reader
    import vga_pkg::*;
#(
    parameter int H_VISIBLE   = C_H_VISIBLE,
    parameter int H_FRONT     = C_H_FRONT,
    parameter int H_SYNC      = C_H_SYNC,
    parameter int H_BACK      = C_H_BACK,
    parameter int V_VISIBLE   = C_V_VISIBLE,
    parameter int V_FRONT     = C_V_FRONT,
    parameter int V_SYNC      = C_V_SYNC,
    parameter int V_BACK      = C_V_BACK,
    parameter int SCALE_SHIFT = 2,
    parameter int COLOUR_W    = C_COLOUR_W,
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = C_CNT_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                pix_en,
    output logic [7:0]          rd_x,
    output logic [6:0]          rd_y,
    output logic                rd_en,
    input  logic [COLOUR_W-1:0] rd_colour,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic                vga_blank_n,
    output logic                frame_start
);

    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_visible;
    logic             w_hs_raw;
    logic             w_vs_raw;
    align_t           w_stage0;
    align_t           w_last;

    align_t              r_align [MEM_LATENCY];
    logic [COLOUR_W-1:0] r_vga_colour;
    logic                r_vga_hs;
    logic                r_vga_vs;
    logic                r_vga_blank_n;

    vga_timing_gen #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .CNT_W     (CNT_W)
    ) u_timing (
        .clk           (clk),
        .resetn        (resetn),
        .i_pix_en      (pix_en),
        .o_h_cnt       (w_h_cnt),
        .o_v_cnt       (w_v_cnt),
        .o_visible     (w_visible),
        .o_hs_raw      (w_hs_raw),
        .o_vs_raw      (w_vs_raw),
        .o_frame_start (frame_start)
    );

    // Address generation: downscale screen position to framebuffer cell.
    // The address is parked at 0 during blanking so the RAM sees a stable,
    // in-range address.
    assign rd_en = w_visible;
    assign rd_x  = w_visible ? 8'(w_h_cnt >> SCALE_SHIFT) : 8'd0;
    assign rd_y  = w_visible ? 7'(w_v_cnt >> SCALE_SHIFT) : 7'd0;

    assign w_stage0 = '{visible: w_visible, hs: w_hs_raw, vs: w_vs_raw};

    // Delay line matching the framebuffer read latency, so the flags leaving
    // the last stage belong to the same pixel as the rd_colour now arriving.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                r_align[i] <= C_ALIGN_IDLE;
            end
        end else if (pix_en) begin
            r_align[0] <= w_stage0;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_align[i] <= r_align[i-1];
            end
        end
    end

    assign w_last = r_align[MEM_LATENCY-1];

    // Output registers: all VGA pins update together on the same tick
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_vga_colour  <= '0;
            r_vga_hs      <= ~C_SYNC_ACTIVE;
            r_vga_vs      <= ~C_SYNC_ACTIVE;
            r_vga_blank_n <= 1'b0;
        end else if (pix_en) begin
            r_vga_colour  <= w_last.visible ? rd_colour : '0;
            r_vga_hs      <= w_last.hs;
            r_vga_vs      <= w_last.vs;
            r_vga_blank_n <= w_last.visible;
        end
    end

    assign vga_colour  = r_vga_colour;
    assign vga_hs      = r_vga_hs;
    assign vga_vs      = r_vga_vs;
    assign vga_blank_n = r_vga_blank_n;

endmodule : vga_scanout_reader
`default_nettype wire

// File: tb/tb_vga_scanout_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_scanout_reader
//  Description : Self-checking bench. Two instances share clk/resetn/pix_en:
//                u_dut0 with the default 640x480 timing and 1-tick memory,
//                u_dut1 with a shrunken raster and 2-tick memory so whole
//                frames fit in a short run. Expected outputs are derived
//                from the number of pix_en ticks since reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_scanout_reader;

    localparam int NI = 2;
    localparam int HV [NI] = '{640, 32};
    localparam int HF [NI] = '{16, 4};
    localparam int HS [NI] = '{96, 6};
    localparam int HB [NI] = '{48, 6};
    localparam int VV [NI] = '{480, 24};
    localparam int VF [NI] = '{10, 3};
    localparam int VS [NI] = '{2, 2};
    localparam int VB [NI] = '{33, 3};
    localparam int LAT[NI] = '{1, 2};

    logic clk = 1'b0;
    logic resetn;
    logic pix_en;

    logic [7:0] d0_x, d1_x;
    logic [6:0] d0_y, d1_y;
    logic       d0_en, d1_en;
    logic [2:0] d0_rdc, d1_rdc;
    logic [2:0] d0_col, d1_col;
    logic       d0_hs, d1_hs, d0_vs, d1_vs, d0_bn, d1_bn, d0_fs, d1_fs;

    logic [2:0] mem [120][160];
    logic [2:0] q0, q1a, q1b, garb;

    int  n = 0;
    bit  fs_exp [NI];
    bit  armed = 0;
    int  n_chk = 0;
    int  n_pass = 0;

    always #5 clk = ~clk;

    vga_scanout_reader u_dut0 (
        .clk(clk), .resetn(resetn), .pix_en(pix_en),
        .rd_x(d0_x), .rd_y(d0_y), .rd_en(d0_en), .rd_colour(d0_rdc),
        .vga_colour(d0_col), .vga_hs(d0_hs), .vga_vs(d0_vs),
        .vga_blank_n(d0_bn), .frame_start(d0_fs)
    );

    vga_scanout_reader #(
        .H_VISIBLE(32), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
        .V_VISIBLE(24), .V_FRONT(3), .V_SYNC(2), .V_BACK(3),
        .MEM_LATENCY(2)
    ) u_dut1 (
        .clk(clk), .resetn(resetn), .pix_en(pix_en),
        .rd_x(d1_x), .rd_y(d1_y), .rd_en(d1_en), .rd_colour(d1_rdc),
        .vga_colour(d1_col), .vga_hs(d1_hs), .vga_vs(d1_vs),
        .vga_blank_n(d1_bn), .frame_start(d1_fs)
    );

    // Framebuffer RAM models; an unrequested read returns all-ones junk,
    // and between ticks the data bus carries random noise.
    always @(posedge clk) begin
        if (pix_en) begin
            q0  <= d0_en ? mem[d0_y][d0_x] : 3'b111;
            q1a <= d1_en ? mem[d1_y][d1_x] : 3'b111;
            q1b <= q1a;
        end
    end
    always @(negedge clk) garb = 3'($urandom);
    assign d0_rdc = pix_en ? q0  : garb;
    assign d1_rdc = pix_en ? q1b : garb;

    // Tick counter: the whole expected raster is a function of n
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            fs_exp[i] = resetn && pix_en &&
                        ((n % ((HV[i]+HF[i]+HS[i]+HB[i]) * (VV[i]+VF[i]+VS[i]+VB[i]))) == 0);
        end
        if (!resetn)     n = 0;
        else if (pix_en) n = n + 1;
        armed = 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t n=%0d)", name, act, exp, $time, n);
    endtask

    task automatic check_inst(input int i, input logic [7:0] x, input logic [6:0] y,
                              input logic en, input logic [2:0] col, input logic hs,
                              input logic vs, input logic bn, input logic fs);
        int ht, vt, h, v, m, hm, vm;
        bit ev, evm;
        int ex, ey, ecol, ehs, evs, ebn;
        ht = HV[i] + HF[i] + HS[i] + HB[i];
        vt = VV[i] + VF[i] + VS[i] + VB[i];
        h  = n % ht;
        v  = (n / ht) % vt;
        ev = (h < HV[i]) && (v < VV[i]);
        ex = ev ? (h >> 2) : 0;
        ey = ev ? (v >> 2) : 0;
        if (n < LAT[i] + 1) begin
            ecol = 0; ehs = 1; evs = 1; ebn = 0;
        end else begin
            m    = n - LAT[i] - 1;
            hm   = m % ht;
            vm   = (m / ht) % vt;
            evm  = (hm < HV[i]) && (vm < VV[i]);
            ebn  = evm ? 1 : 0;
            ehs  = (hm >= HV[i]+HF[i] && hm < HV[i]+HF[i]+HS[i]) ? 0 : 1;
            evs  = (vm >= VV[i]+VF[i] && vm < VV[i]+VF[i]+VS[i]) ? 0 : 1;
            ecol = evm ? int'(mem[vm>>2][hm>>2]) : 0;
        end
        chk($sformatf("u%0d rd_x", i), int'(x), ex);
        chk($sformatf("u%0d rd_y", i), int'(y), ey);
        chk($sformatf("u%0d rd_en", i), int'(en), ev ? 1 : 0);
        chk($sformatf("u%0d vga_colour", i), int'(col), ecol);
        chk($sformatf("u%0d vga_hs", i), int'(hs), ehs);
        chk($sformatf("u%0d vga_vs", i), int'(vs), evs);
        chk($sformatf("u%0d vga_blank_n", i), int'(bn), ebn);
        chk($sformatf("u%0d frame_start", i), int'(fs), fs_exp[i] ? 1 : 0);
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (armed) begin
            check_inst(0, d0_x, d0_y, d0_en, d0_col, d0_hs, d0_vs, d0_bn, d0_fs);
            check_inst(1, d1_x, d1_y, d1_en, d1_col, d1_hs, d1_vs, d1_bn, d1_fs);
        end
    end

    // Advance (pix_en held high) until the tick count reaches target
    task automatic run_to(input int target);
        int budget;
        budget = 0;
        while (n != target && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        chk("reach tick", n, target);
    endtask

    logic [2:0] pat [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1};

    initial begin
        int budget;
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++)
                mem[yy][xx] = (yy == 0) ? 3'(xx) : 3'($urandom);

        resetn = 1'b0;
        pix_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset vga_hs", int'(d0_hs), 1);
        chk("reset vga_vs", int'(d0_vs), 1);
        chk("reset blank_n", int'(d0_bn), 0);
        chk("reset colour", int'(d0_col), 0);
        chk("reset frame_start", int'(d0_fs), 0);
        chk("reset rd_x", int'(d0_x), 0);
        chk("reset rd_y", int'(d0_y), 0);
        chk("reset rd_en", int'(d0_en), 1);
        resetn = 1'b1;

        // Row 0 colour equals rd_x[2:0], one tick of memory plus output reg
        for (int k = 0; k < 8; k++) begin
            run_to(k + 2);
            chk("row0 colour", int'(d0_col), int'(pat[k]));
            chk("row0 blank_n", int'(d0_bn), 1);
        end
        run_to(642);
        chk("hblank colour", int'(d0_col), 0);
        chk("hblank blank_n", int'(d0_bn), 0);
        run_to(657);  chk("hs before fall", int'(d0_hs), 1);
        run_to(658);  chk("hs fall", int'(d0_hs), 0);
        run_to(753);  chk("hs before rise", int'(d0_hs), 0);
        run_to(754);  chk("hs rise", int'(d0_hs), 1);
        run_to(1298); chk("u1 vs before fall", int'(d1_vs), 1);
        run_to(1299); chk("u1 vs fall", int'(d1_vs), 0);
        run_to(1394); chk("u1 vs before rise", int'(d1_vs), 0);
        run_to(1395); chk("u1 vs rise", int'(d1_vs), 1);
        run_to(1537); chk("u1 frame_start", int'(d1_fs), 1);
        run_to(1538); chk("u1 frame_start low", int'(d1_fs), 0);
        for (int k = 4; k < 8; k++) begin
            run_to(9*800 + k);
            chk("v9 rd_x", int'(d0_x), 1);
            chk("v9 rd_y", int'(d0_y), 2);
            chk("v9 rd_en", int'(d0_en), 1);
        end
        run_to(9*800 + 639); chk("h639 rd_x", int'(d0_x), 159);
        run_to(9*800 + 640);
        chk("h640 rd_en", int'(d0_en), 0);
        chk("h640 rd_x", int'(d0_x), 0);

        // Half-rate strobe, then random strobe
        repeat (6000) begin
            pix_en = ~pix_en;
            @(negedge clk);
        end
        repeat (10000) begin
            pix_en = 1'($urandom_range(0, 1));
            @(negedge clk);
        end

        // Reset in the middle of an hsync pulse
        pix_en = 1'b1;
        budget = 0;
        while ((n % 800) != 700 && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        chk("reach h700", n % 800, 700);
        chk("hs active pre-reset", int'(d0_hs), 0);
        resetn = 1'b0;
        @(negedge clk);
        chk("mid reset vga_hs", int'(d0_hs), 1);
        chk("mid reset blank_n", int'(d0_bn), 0);
        pix_en = 1'b0;
        @(negedge clk);
        chk("reset w/o pix_en hs", int'(d0_hs), 1);
        resetn = 1'b1;
        pix_en = 1'b1;
        @(negedge clk);
        chk("restart frame_start u0", int'(d0_fs), 1);
        chk("restart frame_start u1", int'(d1_fs), 1);
        @(negedge clk);
        chk("restart frame_start u0 low", int'(d0_fs), 0);

        // Random strobe with occasional short resets
        repeat (8000) begin
            pix_en = ($urandom_range(0, 3) != 0);
            resetn = ($urandom_range(0, 1999) != 0);
            @(negedge clk);
        end
        resetn = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_vga_scanout_reader
`default_nettype wire
